// File: rtl/fcl_pkg.sv
// fcl_pkg: shared types, LFSR taps and arithmetic helpers for the
// fully connected layer weight-store controller.
// Optional feature macro: FCL_WEIGHT_CLIP_EN (adds the update clip helper).
package fcl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } wctrl_state_t;

  // Working width for the signed helpers; wide enough for any slice we use
  localparam int CALC_W = 64;

  // LFSR feedback taps: these bit positions are XORed into the new MSB on
  // every right shift. Bit 0 is always a tap, so a non-zero state can never
  // collapse to all-zeros.
  localparam int LFSR_TAP0 = 0;
  localparam int LFSR_TAP1 = 1;
  localparam int LFSR_TAP2 = 18;
  localparam int LFSR_TAP3 = 19;

  // Arithmetic right shift of a sign-extended slice
  function automatic logic signed [CALC_W-1:0] sra_slice(
    input logic signed [CALC_W-1:0] val,
    input int                       sh
  );
    return val >>> sh;
  endfunction

`ifdef FCL_WEIGHT_CLIP_EN
  // Saturate a value to the symmetric range [-lim, lim]
  function automatic logic signed [CALC_W-1:0] clip_val(
    input logic signed [CALC_W-1:0] val,
    input logic signed [CALC_W-1:0] lim
  );
    if (val > lim) begin
      return lim;
    end else if (val < -lim) begin
      return -lim;
    end
    return val;
  endfunction
`endif

endpackage

// File: rtl/fcl_weight_ctrl_if.sv
// fcl_weight_ctrl_if: init request, update handshake and weight/status
// outputs of the weight-store controller. The controller uses the slave
// modport; the layer (or a bench) uses the master modport.
interface fcl_weight_ctrl_if #(
  parameter int WIDTH      = 16,
  parameter int INPUT_DIM  = 4,
  parameter int OUTPUT_DIM = 10,
  parameter int STEP_W     = 16
) ();

  logic                    init_req;
  logic                    upd_valid;
  logic                    upd_ready;
  logic signed [WIDTH-1:0] upd_weights [INPUT_DIM+1][OUTPUT_DIM];
  logic signed [WIDTH-1:0] weights_o   [INPUT_DIM+1][OUTPUT_DIM];
  logic                    busy;
  logic                    init_done;
  logic [STEP_W-1:0]       step_count;

  modport master (
    output init_req, upd_valid, upd_weights,
    input  upd_ready, weights_o, busy, init_done, step_count
  );

  modport slave (
    input  init_req, upd_valid, upd_weights,
    output upd_ready, weights_o, busy, init_done, step_count
  );

endinterface

// File: rtl/fcl_weight_lfsr.sv
// fcl_weight_lfsr: N-bit right-shifting Fibonacci LFSR that supplies one
// full row of pseudo-random weights per step. Reseeded on reset or load.
module fcl_weight_lfsr
  import fcl_pkg::*;
#(
  parameter int           N    = 160,
  parameter logic [N-1:0] SEED = N'(1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  output logic [N-1:0] state
);

  logic [N-1:0] state_reg;
  logic         feedback;

  assign feedback = state_reg[LFSR_TAP0] ^ state_reg[LFSR_TAP1] ^
                    state_reg[LFSR_TAP2] ^ state_reg[LFSR_TAP3];

  // Seed on reset/load, otherwise shift right with feedback into the MSB
  always_ff @(posedge clk) begin
    if (reset || load) begin
      state_reg <= SEED;
    end else if (en) begin
      state_reg <= {feedback, state_reg[N-1:1]};
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/fcl_weight_ctrl.sv
// fcl_weight_ctrl: owns the (INPUT_DIM+1) x OUTPUT_DIM signed weight/bias
// array. INIT fills one row per cycle from the LFSR (slice >>> INIT_SHIFT);
// RUN accepts complete updated sets over a valid/ready handshake and counts
// accepted updates with a saturating counter.
// Optional feature macro: FCL_WEIGHT_CLIP_EN (clip accepted updates to
// [-CLIP_MAX, CLIP_MAX]; init values are never clipped).
module fcl_weight_ctrl
  import fcl_pkg::*;
#(
  parameter int                          WIDTH      = 16,
  parameter int                          INPUT_DIM  = 4,
  parameter int                          OUTPUT_DIM = 10,
  parameter int                          INIT_SHIFT = 4,
  parameter logic [WIDTH*OUTPUT_DIM-1:0] LFSR_SEED  = {{(WIDTH*OUTPUT_DIM-1){1'b0}}, 1'b1},
  parameter bit                          AUTO_INIT  = 1'b1,
  parameter int                          STEP_W     = 16,
  parameter int                          CLIP_MAX   = 2**(WIDTH-2)
) (
  input logic               clk,
  input logic               reset,
  fcl_weight_ctrl_if.slave  bus
);

  localparam int               ROWS     = INPUT_DIM + 1;
  localparam int               LFSR_N   = WIDTH * OUTPUT_DIM;
  localparam int               ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(INPUT_DIM);

  wctrl_state_t            state_reg;
  wctrl_state_t            state_next;
  logic [ROW_W-1:0]        row_idx_reg;
  logic                    auto_pend_reg;
  logic                    init_done_reg;
  logic [STEP_W-1:0]       step_count_reg;
  logic                    start_init;
  logic                    init_active;
  logic                    init_last;
  logic                    upd_ready_int;
  logic                    xfer;
  logic [LFSR_N-1:0]       lfsr_state;
  logic signed [WIDTH-1:0] init_col [OUTPUT_DIM];

  assign init_active   = (state_reg == INIT);
  assign init_last     = init_active && (row_idx_reg == LAST_ROW);
  // A pending init request blocks acceptance so init always wins a collision
  assign upd_ready_int = (state_reg == RUN) && !bus.init_req;
  assign xfer          = bus.upd_valid && upd_ready_int;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; start_init flags every entry into INIT
  always_comb begin
    state_next = state_reg;
    start_init = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.init_req || auto_pend_reg) begin
          state_next = INIT;
          start_init = 1'b1;
        end
      end
      INIT: begin
        if (row_idx_reg == LAST_ROW) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.init_req) begin
          state_next = INIT;
          start_init = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Auto-start flag: live only in the first cycle after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      auto_pend_reg <= AUTO_INIT;
    end else begin
      auto_pend_reg <= 1'b0;
    end
  end

  // Row pointer: cleared on INIT entry, walks 0..INPUT_DIM and stops there
  always_ff @(posedge clk) begin
    if (reset || start_init) begin
      row_idx_reg <= '0;
    end else if (init_active && !init_last) begin
      row_idx_reg <= row_idx_reg + ROW_W'(1);
    end
  end

  // init_done pulses in the first RUN cycle after the last row is written
  always_ff @(posedge clk) begin
    if (reset) begin
      init_done_reg <= 1'b0;
    end else begin
      init_done_reg <= init_last;
    end
  end

  // Accepted-update counter: cleared on INIT->RUN, saturates at all-ones
  always_ff @(posedge clk) begin
    if (reset || init_last) begin
      step_count_reg <= '0;
    end else if (xfer && (step_count_reg != '1)) begin
      step_count_reg <= step_count_reg + STEP_W'(1);
    end
  end

  fcl_weight_lfsr #(
    .N    (LFSR_N),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (start_init),
    .en    (init_active),
    .state (lfsr_state)
  );

  // Per-column init value: signed LFSR slice shifted down arithmetically
  for (genvar gj = 0; gj < OUTPUT_DIM; gj++) begin : g_init_col
    assign init_col[gj] = WIDTH'(sra_slice(CALC_W'($signed(lfsr_state[gj*WIDTH +: WIDTH])),
                                           INIT_SHIFT));
  end

  // Weight array: one register per element, written by update or by INIT
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < OUTPUT_DIM; gj++) begin : g_col
      logic signed [WIDTH-1:0] upd_val;
      logic signed [WIDTH-1:0] w_reg;

`ifdef FCL_WEIGHT_CLIP_EN
      assign upd_val = WIDTH'(clip_val(CALC_W'(bus.upd_weights[gi][gj]), CALC_W'(CLIP_MAX)));
`else
      assign upd_val = bus.upd_weights[gi][gj];
`endif

      // Update has priority; INIT only touches the row under the pointer
      always_ff @(posedge clk) begin
        if (reset) begin
          w_reg <= '0;
        end else if (xfer) begin
          w_reg <= upd_val;
        end else if (init_active && (row_idx_reg == ROW_W'(gi))) begin
          w_reg <= init_col[gj];
        end
      end

      assign bus.weights_o[gi][gj] = w_reg;
    end
  end

  assign bus.upd_ready  = upd_ready_int;
  assign bus.busy       = init_active;
  assign bus.init_done  = init_done_reg;
  assign bus.step_count = step_count_reg;

endmodule

// File: tb/tb_fcl_weight_ctrl.sv
// tb_fcl_weight_ctrl: directed sequence with random weight sets, checked
// against a behavioural model (LFSR sequence, floor-division shift, clip).
// dut_a: AUTO_INIT=1, STEP_W=16.  dut_b: AUTO_INIT=0, STEP_W=2.
`timescale 1ns/1ps
module tb_fcl_weight_ctrl;

  localparam int WIDTH      = 16;
  localparam int INPUT_DIM  = 4;
  localparam int OUTPUT_DIM = 10;
  localparam int ROWS       = INPUT_DIM + 1;
  localparam int INIT_SHIFT = 4;
  localparam int N          = WIDTH * OUTPUT_DIM;
  localparam int CLIP_MAX   = 16384;

  typedef logic signed [WIDTH-1:0] wmat_t [ROWS][OUTPUT_DIM];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  reset_a;
  logic  reset_b;
  int    vectors     = 0;
  int    miscompares = 0;
  wmat_t drv_a, drv_b, obs_a, obs_b;
  wmat_t exp_init, exp_w, zero_m, s;
  int    exp_cnt;

  fcl_weight_ctrl_if #(.WIDTH(WIDTH), .INPUT_DIM(INPUT_DIM), .OUTPUT_DIM(OUTPUT_DIM), .STEP_W(16)) bus_a ();
  fcl_weight_ctrl_if #(.WIDTH(WIDTH), .INPUT_DIM(INPUT_DIM), .OUTPUT_DIM(OUTPUT_DIM), .STEP_W(2))  bus_b ();

  fcl_weight_ctrl #(
    .WIDTH(WIDTH), .INPUT_DIM(INPUT_DIM), .OUTPUT_DIM(OUTPUT_DIM), .INIT_SHIFT(INIT_SHIFT),
    .LFSR_SEED(160'd1), .AUTO_INIT(1'b1), .STEP_W(16), .CLIP_MAX(CLIP_MAX)
  ) dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));

  fcl_weight_ctrl #(
    .WIDTH(WIDTH), .INPUT_DIM(INPUT_DIM), .OUTPUT_DIM(OUTPUT_DIM), .INIT_SHIFT(INIT_SHIFT),
    .LFSR_SEED(160'd1), .AUTO_INIT(1'b0), .STEP_W(2), .CLIP_MAX(CLIP_MAX)
  ) dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

  assign bus_a.upd_weights = drv_a;
  assign bus_b.upd_weights = drv_b;
  assign obs_a = bus_a.weights_o;
  assign obs_b = bus_b.weights_o;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_rows(input string tag, input wmat_t obs, input wmat_t expm);
    for (int r = 0; r < ROWS; r++) begin
      logic [N-1:0] o;
      logic [N-1:0] e;
      for (int c = 0; c < OUTPUT_DIM; c++) begin
        o[c*WIDTH +: WIDTH] = obs[r][c];
        e[c*WIDTH +: WIDTH] = expm[r][c];
      end
      vectors++;
      assert (o === e) else begin
        miscompares++;
        $error("FAIL %s row%0d observed=%h expected=%h", tag, r, o, e);
      end
    end
  endtask

  // Reference LFSR step: shift right, XOR of the tap bits enters at the top
  function automatic logic [N-1:0] lfsr_model_step(input logic [N-1:0] st);
    logic fb;
    fb = st[fcl_pkg::LFSR_TAP0] ^ st[fcl_pkg::LFSR_TAP1] ^
         st[fcl_pkg::LFSR_TAP2] ^ st[fcl_pkg::LFSR_TAP3];
    return (st >> 1) | ({{(N-1){1'b0}}, fb} << (N-1));
  endfunction

  // Expected init rows: floor(slice / 2**INIT_SHIFT) per column
  task automatic compute_init();
    logic [N-1:0] st;
    int           v;
    int           d;
    st = {{(N-1){1'b0}}, 1'b1};
    d  = 1 << INIT_SHIFT;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < OUTPUT_DIM; c++) begin
        v = $signed(st[c*WIDTH +: WIDTH]);
        v = (v >= 0) ? (v / d) : -((-v + d - 1) / d);
        exp_init[r][c] = WIDTH'(v);
      end
      st = lfsr_model_step(st);
    end
  endtask

  function automatic logic signed [WIDTH-1:0] store_model(input logic signed [WIDTH-1:0] x);
    int v;
    v = x;
`ifdef FCL_WEIGHT_CLIP_EN
    if (v > CLIP_MAX) v = CLIP_MAX;
    else if (v < -CLIP_MAX) v = -CLIP_MAX;
`endif
    return WIDTH'(v);
  endfunction

  task automatic gen_set(output wmat_t m);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < OUTPUT_DIM; c++)
        m[r][c] = WIDTH'($urandom);
  endtask

  task automatic apply_set(input wmat_t m, output wmat_t res);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < OUTPUT_DIM; c++)
        res[r][c] = store_model(m[r][c]);
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    bus_a.init_req = 1'b0; bus_a.upd_valid = 1'b0;
    bus_b.init_req = 1'b0; bus_b.upd_valid = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < OUTPUT_DIM; c++)
        zero_m[r][c] = '0;
    drv_a = zero_m; drv_b = zero_m;
    compute_init();
    repeat (3) tick();

    // ---- dut_a reset state ----
    bus_a.upd_valid = 1'b1; #1;
    chk("a_rst_busy", bus_a.busy, 0);
    chk("a_rst_done", bus_a.init_done, 0);
    chk("a_rst_step", bus_a.step_count, 0);
    chk("a_rst_ready", bus_a.upd_ready, 0);
    check_rows("a_rst_w", obs_a, zero_m);
    bus_a.upd_valid = 1'b0;

    // ---- auto init timing: cycle 0 idle, cycles 1-5 busy, cycle 6 done ----
    reset_a = 1'b0; #1;
    chk("a_c0_busy", bus_a.busy, 0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      gen_set(s); drv_a = s;
      bus_a.init_req  = (c == 2);
      bus_a.upd_valid = 1'b1;
      #1;
      chk($sformatf("a_init_c%0d_busy", c), bus_a.busy, 1);
      chk($sformatf("a_init_c%0d_done", c), bus_a.init_done, 0);
      chk($sformatf("a_init_c%0d_ready", c), bus_a.upd_ready, 0);
    end
    bus_a.init_req = 1'b0; bus_a.upd_valid = 1'b0;
    tick();
    chk("a_c6_done", bus_a.init_done, 1);
    chk("a_c6_busy", bus_a.busy, 0);
    chk("a_c6_step", bus_a.step_count, 0);
    check_rows("a_c6_w", obs_a, exp_init);
    tick();
    chk("a_c7_done", bus_a.init_done, 0);
    exp_w = exp_init; exp_cnt = 0;

    // ---- handshake: three updates with one valid gap ----
    for (int k = 0; k < 4; k++) begin
      gen_set(s); drv_a = s;
      bus_a.upd_valid = (k != 2);
      #1;
      chk("a_hs_ready", bus_a.upd_ready, 1);
      tick();
      if (k != 2) begin
        apply_set(s, exp_w);
        exp_cnt++;
      end
      check_rows("a_hs_w", obs_a, exp_w);
      chk("a_hs_step", bus_a.step_count, 64'(exp_cnt));
    end

    // ---- init_req collides with upd_valid: init wins ----
    gen_set(s); drv_a = s;
    bus_a.upd_valid = 1'b1; bus_a.init_req = 1'b1; #1;
    chk("a_col_ready", bus_a.upd_ready, 0);
    tick();
    bus_a.upd_valid = 1'b0; bus_a.init_req = 1'b0; #1;
    chk("a_col_busy", bus_a.busy, 1);
    chk("a_col_step", bus_a.step_count, 3);
    check_rows("a_col_w", obs_a, exp_w);
    tick();
    for (int c = 0; c < OUTPUT_DIM; c++) exp_w[0][c] = exp_init[0][c];
    check_rows("a_reinit_partial", obs_a, exp_w);
    repeat (4) tick();
    chk("a_reinit_done", bus_a.init_done, 1);
    chk("a_reinit_step", bus_a.step_count, 0);
    check_rows("a_reinit_w", obs_a, exp_init);

    // ---- two more updates, then reset in INIT cycle 3 ----
    for (int k = 0; k < 2; k++) begin
      gen_set(s); drv_a = s; bus_a.upd_valid = 1'b1;
      tick();
      apply_set(s, exp_w);
      check_rows("a_upd2_w", obs_a, exp_w);
    end
    chk("a_upd2_step", bus_a.step_count, 2);
    bus_a.upd_valid = 1'b0; bus_a.init_req = 1'b1;
    tick();                             // INIT cycle 1
    bus_a.init_req = 1'b0;
    tick();                             // INIT cycle 2
    tick();                             // INIT cycle 3
    chk("a_mid_busy", bus_a.busy, 1);
    reset_a = 1'b1; bus_a.upd_valid = 1'b1;
    tick();
    chk("a_abort_busy", bus_a.busy, 0);
    chk("a_abort_done", bus_a.init_done, 0);
    chk("a_abort_step", bus_a.step_count, 0);
    chk("a_abort_ready", bus_a.upd_ready, 0);
    check_rows("a_abort_w", obs_a, zero_m);
    reset_a = 1'b0; bus_a.upd_valid = 1'b0;
    tick();
    chk("a_restart_busy", bus_a.busy, 1);

    // ---- dut_b: AUTO_INIT=0 stays idle for 20 cycles ----
    reset_b = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      gen_set(s); drv_b = s; bus_b.upd_valid = 1'b1; #1;
      chk("b_idle_busy", bus_b.busy, 0);
      chk("b_idle_ready", bus_b.upd_ready, 0);
      check_rows("b_idle_w", obs_b, zero_m);
    end
    bus_b.upd_valid = 1'b0; bus_b.init_req = 1'b1;
    tick();
    bus_b.init_req = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) tick();
      chk($sformatf("b_init_c%0d_busy", c), bus_b.busy, 1);
    end
    tick();
    chk("b_init_done", bus_b.init_done, 1);
    chk("b_init_busy", bus_b.busy, 0);
    check_rows("b_init_w", obs_b, exp_init);

    // ---- dut_b: five updates, 2-bit counter saturates at 3 ----
    for (int k = 0; k < 5; k++) begin
      gen_set(s);
      if (k == 0) begin
        s[0][0] = 16'sd30000;
        s[1][3] = -16'sd20000;
        s[4][9] = 16'sd100;
      end
      drv_b = s; bus_b.upd_valid = 1'b1;
      tick();
      apply_set(s, exp_w);
      check_rows("b_upd_w", obs_b, exp_w);
      chk("b_upd_step", bus_b.step_count, 64'((k + 1 > 3) ? 3 : k + 1));
      if (k == 0) begin
`ifdef FCL_WEIGHT_CLIP_EN
        chk("b_clip_pos", 64'(int'(obs_b[0][0])), 64'(16384));
        chk("b_clip_neg", 64'(int'(obs_b[1][3])), 64'(-16384));
`else
        chk("b_noclip_pos", 64'(int'(obs_b[0][0])), 64'(30000));
        chk("b_noclip_neg", 64'(int'(obs_b[1][3])), 64'(-20000));
`endif
        chk("b_small", 64'(int'(obs_b[4][9])), 64'(100));
      end
    end
    bus_b.upd_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
